csr_irq_unit: RTL and testbench

- Machine-mode interrupt unit that owns the MIE and MIP CSRs for the core.
- Extends the fixed three-source interrupt set (software/timer/external) with NUM_LOCAL_IRQ platform-local interrupts at mcause codes 16 and up, each selectable as level- or edge-triggered.
- Performs fixed-priority arbitration and produces a stable, registered trap request carrying the mcause value and the direct/vectored handler address.
- Sits beside the CSR file. The core's trap logic consumes it through a req/ack handshake.

---
 rtl/csr_irq_unit.sv | 194 +++++++++++++++++++
 tb/tb_csr_irq_unit.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/csr_irq_unit.sv
// csr_irq_unit: machine-mode MIE/MIP owner with level/edge local interrupts,
// fixed-priority arbitration and a registered req/ack trap request.
`default_nettype none

module csr_irq_unit #(
    parameter int NUM_LOCAL_IRQ = 4,
    parameter logic [((NUM_LOCAL_IRQ > 0) ? NUM_LOCAL_IRQ : 1)-1:0] LOCAL_EDGE_MASK = '0
) (
    input  logic                                             clk_i,
    input  logic                                             rstn_i,
    input  logic                                             irq_software_i,
    input  logic                                             irq_timer_i,
    input  logic                                             irq_external_i,
    input  logic [((NUM_LOCAL_IRQ > 0) ? NUM_LOCAL_IRQ : 1)-1:0] irq_local_i,
    input  logic                                             mstatus_mie_i,
    input  logic [31:0]                                      mtvec_i,
    input  logic                                             csr_we_i,
    input  logic [11:0]                                      csr_addr_i,
    input  logic [31:0]                                      csr_wdata_i,
    output logic [31:0]                                      csr_rdata_o,
    output logic                                             irq_req_o,
    output logic [31:0]                                      irq_cause_o,
    output logic [31:0]                                      irq_target_o,
    input  logic                                             irq_ack_i
);

    localparam int          LW         = (NUM_LOCAL_IRQ > 0) ? NUM_LOCAL_IRQ : 1;
    localparam logic [11:0] c_ADDR_MIE = 12'h304;
    localparam logic [11:0] c_ADDR_MIP = 12'h344;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_REQ   = 2'd1,
        S_CLEAR = 2'd2
    } state_t;

    state_t      r_state, w_state_nxt;
    logic        r_req, w_req_nxt;
    logic [31:0] r_cause, w_cause_nxt;
    logic [31:0] r_target, w_target_nxt;
    logic [2:0]  r_mie_std;             // {MEIE, MTIE, MSIE}

    logic [LW-1:0] w_loc_mip, w_loc_mie;
    logic [31:0]   w_mip, w_mie, w_elig;
    logic          w_win_valid;
    logic [4:0]    w_win_code;
    logic [31:0]   w_base, w_target;
    logic          w_wr_mie, w_wr_mip, w_ack_take;
    logic          w_unused_bits;

    assign w_wr_mie   = csr_we_i && (csr_addr_i == c_ADDR_MIE);
    assign w_wr_mip   = csr_we_i && (csr_addr_i == c_ADDR_MIP);
    assign w_ack_take = (r_state == S_REQ) && irq_ack_i;
    assign w_unused_bits = ^{csr_wdata_i, irq_local_i};

    generate
        if (NUM_LOCAL_IRQ > 0) begin : g_local
            logic [LW-1:0] r_mie_loc, r_prev, r_pend;
            logic [LW-1:0] w_rise, w_clr;

            assign w_rise    = irq_local_i & ~r_prev & LOCAL_EDGE_MASK;
            assign w_loc_mie = r_mie_loc;

            always_comb begin
                w_loc_mip = '0;
                w_clr     = '0;
                for (int i = 0; i < LW; i++) begin
                    w_loc_mip[i] = LOCAL_EDGE_MASK[i] ? r_pend[i] : irq_local_i[i];
                    w_clr[i]     = (w_wr_mip && !csr_wdata_i[16+i]) ||
                                   (w_ack_take && (r_cause[4:0] == 5'(16 + i)));
                end
            end

            // A new rising edge beats a same-cycle clear so no edge is lost.
            always_ff @(posedge clk_i or negedge rstn_i) begin
                if (!rstn_i) begin
                    r_mie_loc <= '0;
                    r_prev    <= '0;
                    r_pend    <= '0;
                end else begin
                    if (w_wr_mie)
                        r_mie_loc <= csr_wdata_i[16 +: LW];
                    r_prev <= irq_local_i;
                    r_pend <= ((r_pend & ~w_clr) | w_rise) & LOCAL_EDGE_MASK;
                end
            end
        end else begin : g_no_local
            assign w_loc_mip = '0;
            assign w_loc_mie = '0;
        end
    endgenerate

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i)
            r_mie_std <= 3'b000;
        else if (w_wr_mie)
            r_mie_std <= {csr_wdata_i[11], csr_wdata_i[7], csr_wdata_i[3]};
    end

    always_comb begin
        w_mip     = '0;
        w_mie     = '0;
        w_mip[3]  = irq_software_i;
        w_mip[7]  = irq_timer_i;
        w_mip[11] = irq_external_i;
        w_mie[3]  = r_mie_std[0];
        w_mie[7]  = r_mie_std[1];
        w_mie[11] = r_mie_std[2];
        for (int i = 0; i < NUM_LOCAL_IRQ; i++) begin
            w_mip[16+i] = w_loc_mip[i];
            w_mie[16+i] = w_loc_mie[i];
        end
    end

    assign w_elig = w_mip & w_mie & {32{mstatus_mie_i}};

    // Walk lowest to highest priority so the last hit wins.
    always_comb begin
        w_win_code = 5'd0;
        if (w_elig[7])  w_win_code = 5'd7;
        if (w_elig[3])  w_win_code = 5'd3;
        if (w_elig[11]) w_win_code = 5'd11;
        for (int i = 0; i < NUM_LOCAL_IRQ; i++)
            if (w_elig[16+i]) w_win_code = 5'(16 + i);
    end

    assign w_win_valid = |w_elig;
    assign w_base      = {mtvec_i[31:2], 2'b00};
    assign w_target    = (mtvec_i[1:0] == 2'b01) ? (w_base + {25'd0, w_win_code, 2'b00})
                                                 : w_base;

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            r_state  <= S_IDLE;
            r_req    <= 1'b0;
            r_cause  <= '0;
            r_target <= '0;
        end else begin
            r_state  <= w_state_nxt;
            r_req    <= w_req_nxt;
            r_cause  <= w_cause_nxt;
            r_target <= w_target_nxt;
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_req_nxt    = r_req;
        w_cause_nxt  = r_cause;
        w_target_nxt = r_target;
        case (r_state)
            S_IDLE: begin
                if (w_win_valid) begin
                    w_req_nxt    = 1'b1;
                    w_cause_nxt  = {1'b1, 26'd0, w_win_code};
                    w_target_nxt = w_target;
                    w_state_nxt  = S_REQ;
                end
            end
            S_REQ: begin
                if (irq_ack_i) begin
                    w_req_nxt   = 1'b0;
                    w_state_nxt = S_CLEAR;
                end else if (!w_elig[r_cause[4:0]]) begin
                    w_req_nxt   = 1'b0;
                    w_state_nxt = S_IDLE;
                end
            end
            S_CLEAR: begin
                w_req_nxt   = 1'b0;
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_req_nxt   = 1'b0;
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_comb begin
        case (csr_addr_i)
            c_ADDR_MIE: csr_rdata_o = w_mie;
            c_ADDR_MIP: csr_rdata_o = w_mip;
            default:    csr_rdata_o = '0;
        endcase
    end

    assign irq_req_o    = r_req;
    assign irq_cause_o  = r_cause;
    assign irq_target_o = r_target;

endmodule

`default_nettype wire

// File: tb/tb_csr_irq_unit.sv
// tb_csr_irq_unit: vector table plus hand sequences against csr_irq_unit.
`default_nettype none

module tb_csr_irq_unit;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        sw = 1'b0, tm = 1'b0, ex = 1'b0;
    logic [3:0]  loc = 4'b0;
    logic        mst = 1'b0;
    logic [31:0] mtvec = '0;
    logic        we = 1'b0;
    logic [11:0] addr = '0;
    logic [31:0] wdata = '0;
    logic [31:0] rdata;
    logic        req;
    logic [31:0] cause, target;
    logic        ack = 1'b0;

    logic [31:0] rdata0, cause0, target0;
    logic        req0;

    int n_chk = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    csr_irq_unit #(.NUM_LOCAL_IRQ(4), .LOCAL_EDGE_MASK(4'b0001)) dut (
        .clk_i(clk), .rstn_i(rstn),
        .irq_software_i(sw), .irq_timer_i(tm), .irq_external_i(ex),
        .irq_local_i(loc), .mstatus_mie_i(mst), .mtvec_i(mtvec),
        .csr_we_i(we), .csr_addr_i(addr), .csr_wdata_i(wdata),
        .csr_rdata_o(rdata), .irq_req_o(req), .irq_cause_o(cause),
        .irq_target_o(target), .irq_ack_i(ack)
    );

    csr_irq_unit #(.NUM_LOCAL_IRQ(0)) dut0 (
        .clk_i(clk), .rstn_i(rstn),
        .irq_software_i(sw), .irq_timer_i(tm), .irq_external_i(ex),
        .irq_local_i(1'b0), .mstatus_mie_i(mst), .mtvec_i(mtvec),
        .csr_we_i(we), .csr_addr_i(addr), .csr_wdata_i(wdata),
        .csr_rdata_o(rdata0), .irq_req_o(req0), .irq_cause_o(cause0),
        .irq_target_o(target0), .irq_ack_i(ack)
    );

    typedef struct {
        logic [31:0] mie;
        logic [31:0] mtvec;
        logic        sw, tm, ex;
        logic [3:0]  loc;
        logic [31:0] cause;
        logic [31:0] target;
    } vec_t;

    typedef struct {
        logic [31:0] cause;
        logic [31:0] target;
    } exp_t;

    vec_t vecs[6];
    exp_t exp_q[$];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        n_chk++;
        if (act !== expv) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", name, act, expv);
        end
    endtask

    task automatic csr_wr(input logic [11:0] a, input logic [31:0] d);
        we = 1'b1; addr = a; wdata = d;
        tick();
        we = 1'b0;
    endtask

    task automatic csr_rd(input string name, input logic [11:0] a, input logic [31:0] expv);
        addr = a;
        #1;
        chk(name, rdata, expv);
    endtask

    task automatic push_exp(input logic [31:0] c, input logic [31:0] t);
        exp_t e;
        e.cause = c; e.target = t;
        exp_q.push_back(e);
    endtask

    task automatic wait_req(input string name, input int exp_lat);
        int   lat;
        exp_t e;
        lat = 0;
        while (!req && lat < 20) begin
            tick();
            lat++;
        end
        e = exp_q.pop_front();
        if (!req) begin
            n_chk++; n_err++;
            $display("FAIL %s_timeout: got req=0 after %0d cycles, expected req=1", name, lat);
        end else begin
            chk({name, "_lat"}, 32'(lat), 32'(exp_lat));
            chk({name, "_cause"}, cause, e.cause);
            chk({name, "_target"}, target, e.target);
        end
    endtask

    initial begin
        int cnt;
        vecs[0] = '{32'h000F0888, 32'h80000001, 1, 1, 1, 4'b0100, 32'h80000012, 32'h80000048};
        vecs[1] = '{32'h00000888, 32'h80000001, 1, 1, 0, 4'b0000, 32'h80000003, 32'h8000000C};
        vecs[2] = '{32'h00000888, 32'h40000100, 0, 0, 1, 4'b0000, 32'h8000000B, 32'h40000100};
        vecs[3] = '{32'h00000080, 32'h40000103, 0, 1, 1, 4'b0000, 32'h80000007, 32'h40000100};
        vecs[4] = '{32'h000F0000, 32'hFFFFFFE1, 0, 0, 0, 4'b1010, 32'h80000013, 32'h0000002C};
        vecs[5] = '{32'h00000808, 32'h00001001, 1, 0, 1, 4'b0000, 32'h8000000B, 32'h0000102C};

        // reset state
        #2;
        chk("rst_req", {31'd0, req}, 32'd0);
        chk("rst_cause", cause, 32'd0);
        chk("rst_target", target, 32'd0);
        csr_rd("rst_mie", 12'h304, 32'd0);
        csr_rd("rst_mip", 12'h344, 32'd0);
        tick();
        rstn = 1'b1;
        tick();

        // timer in vectored mode, then ack with MIE dropping
        csr_wr(12'h304, 32'h888);
        mst = 1'b1; mtvec = 32'h80000001; tm = 1'b1;
        tick();
        push_exp(32'h80000007, 32'h8000001C);
        wait_req("timer", 0);
        ack = 1'b1; mst = 1'b0;
        tick();
        ack = 1'b0;
        chk("timer_ack_req0", {31'd0, req}, 32'd0);
        tick();
        chk("timer_ack_req1", {31'd0, req}, 32'd0);
        tick();
        chk("timer_ack_req2", {31'd0, req}, 32'd0);
        tm = 1'b0; mst = 1'b1;
        tick();

        for (int v = 0; v < 6; v++) begin
            csr_wr(12'h304, vecs[v].mie);
            mtvec = vecs[v].mtvec;
            sw = vecs[v].sw; tm = vecs[v].tm; ex = vecs[v].ex; loc = vecs[v].loc;
            tick();
            push_exp(vecs[v].cause, vecs[v].target);
            wait_req($sformatf("vec%0d", v), 0);
            ack = 1'b1; sw = 0; tm = 0; ex = 0; loc = 4'b0;
            tick();
            ack = 1'b0;
            chk($sformatf("vec%0d_clear", v), {31'd0, req}, 32'd0);
            tick();
        end

        // latched winner holds, then withdraws and re-arbitrates
        csr_wr(12'h304, 32'h000F0888);
        mtvec = 32'h80000001;
        sw = 1; tm = 1; ex = 1; loc = 4'b0100;
        tick();
        push_exp(32'h80000012, 32'h80000048);
        wait_req("wd_first", 0);
        loc = 4'b1100;
        tick();
        chk("wd_stable_req", {31'd0, req}, 32'd1);
        chk("wd_stable_cause", cause, 32'h80000012);
        loc = 4'b0000;
        tick();
        chk("wd_withdraw", {31'd0, req}, 32'd0);
        push_exp(32'h8000000B, 32'h8000002C);
        wait_req("wd_rereq", 1);
        ack = 1'b1; sw = 0; tm = 0; ex = 0;
        tick();
        ack = 1'b0;
        tick();

        // edge-triggered local 0
        csr_wr(12'h304, 32'h00010000);
        loc = 4'b0001;
        tick();
        loc = 4'b0000;
        chk("edge_req_n1", {31'd0, req}, 32'd0);
        csr_rd("edge_mip_pend", 12'h344, 32'h00010000);
        tick();
        push_exp(32'h80000010, 32'h80000040);
        wait_req("edge", 0);
        csr_rd("edge_mip_req", 12'h344, 32'h00010000);
        ack = 1'b1;
        tick();
        ack = 1'b0;
        csr_rd("edge_mip_acked", 12'h344, 32'h0);
        cnt = 0;
        for (int k = 0; k < 5; k++) begin
            tick();
            if (req) cnt++;
        end
        chk("edge_no_second", 32'(cnt), 32'd0);

        // set beats clear
        csr_wr(12'h304, 32'h0);
        we = 1'b1; addr = 12'h344; wdata = 32'h0; loc = 4'b0001;
        tick();
        we = 1'b0; loc = 4'b0000;
        csr_rd("setwins_mip", 12'h344, 32'h00010000);
        csr_wr(12'h344, 32'h0);
        csr_rd("clr_mip", 12'h344, 32'h0);

        // writable mask, both configurations, and unmapped address
        csr_wr(12'h304, 32'hFFFFFFFF);
        csr_rd("mie_mask", 12'h304, 32'h000F0888);
        chk("mie_mask_n0", rdata0, 32'h00000888);
        csr_rd("unmapped", 12'h300, 32'h0);

        // async reset while requesting
        csr_wr(12'h304, 32'h888);
        mtvec = 32'h80000001; tm = 1'b1;
        tick();
        push_exp(32'h80000007, 32'h8000001C);
        wait_req("prerst", 0);
        rstn = 1'b0;
        #1;
        chk("arst_req", {31'd0, req}, 32'd0);
        chk("arst_cause", cause, 32'd0);
        chk("arst_target", target, 32'd0);
        csr_rd("arst_mie", 12'h304, 32'd0);
        tm = 1'b0;
        tick();
        rstn = 1'b1;
        tick();

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

`default_nettype wire
